jk_bank_arbiter: RTL and testbench

//   Round-robin arbiter sharing one bank of WIDTH JK flip-flops among NREQ requesters.

---
 rtl/jk_arb_pkg.sv | 20 ++
 rtl/jk_cell.sv | 38 +++
 rtl/jk_bank_arbiter.sv | 166 ++++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_arb_pkg.sv
// Shared types and command encodings for the JK bank arbiter.
package jk_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef struct packed {
        logic j;
        logic k;
    } jk_cmd_t;

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with an update enable; holds its value while en is low.
module jk_cell
    import jk_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            case ({j, k})
                JK_CLR:  q_d = 1'b0;
                JK_SET:  q_d = 1'b1;
                JK_TGL:  q_d = ~q_q;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting one JK command at a time onto a shared bank of JK flops.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    cmd,
    input  logic [IDXW*NREQ-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic                 ack,
    output logic                 err,
    output logic                 busy,
    output logic [WIDTH-1:0]     q
);

    localparam int unsigned PTRW = $clog2(NREQ);

    arb_state_e       state_q, state_d;
    logic [PTRW-1:0]  ptr_q,   ptr_d;
    logic [PTRW-1:0]  win_q,   win_d;
    jk_cmd_t          jk_q,    jk_d;
    logic [IDXW-1:0]  idx_q,   idx_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic             ack_q,   ack_d;
    logic             err_q,   err_d;
    logic             busy_q,  busy_d;

    logic [PTRW-1:0]  win_c;
    jk_cmd_t          sel_jk_c;
    logic [IDXW-1:0]  sel_idx_c;
    logic             in_range_c;
    logic [WIDTH-1:0] cell_en_c;

    // First set request at or after p, wrapping at NREQ.
    function automatic logic [PTRW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [PTRW-1:0] p);
        logic [PTRW-1:0] w;
        logic            found;
        int unsigned     c;
        w     = p;
        found = 1'b0;
        for (int unsigned o = 0; o < NREQ; o++) begin
            c = (32'(p) + o) % NREQ;
            if (!found && r[PTRW'(c)]) begin
                w     = PTRW'(c);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Winner selection and mux of the winner's command fields.
    always_comb begin
        win_c     = rr_pick(req, ptr_q);
        sel_jk_c  = jk_cmd_t'(JK_HOLD);
        sel_idx_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_c == PTRW'(i)) begin
                sel_jk_c  = jk_cmd_t'(cmd[2*i +: 2]);
                sel_idx_c = idx[IDXW*i +: IDXW];
            end
        end
    end

    // Extra MSB keeps the compare meaningful when WIDTH is a power of two.
    assign in_range_c = ({1'b0, idx_q} < (IDXW+1)'(WIDTH));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        jk_d    = jk_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d        = win_c;
                    jk_d         = sel_jk_c;
                    idx_d        = sel_idx_c;
                    gnt_d        = '0;
                    gnt_d[win_c] = 1'b1;
                    state_d      = APPLY;
                end else begin
                    gnt_d = '0;
                end
            end
            APPLY: begin
                ack_d   = 1'b1;
                err_d   = ~in_range_c;
                ptr_d   = (win_q == PTRW'(NREQ-1)) ? '0 : win_q + PTRW'(1);
                state_d = DONE;
            end
            DONE: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            jk_q    <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            jk_q    <= jk_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Only the addressed bit sees an enable, and only while applying.
    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cell_en_c[i] = (state_q == APPLY) && in_range_c && (idx_q == IDXW'(i));
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .en  (cell_en_c[g]),
            .j   (jk_q.j),
            .k   (jk_q.k),
            .q   (q[g])
        );
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: transaction-level model plus directed literal checks.
module tb_jk_bank_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDXW  = 3;
    localparam int unsigned W2    = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req,  req2;
    logic [2*NREQ-1:0]    cmd,  cmd2;
    logic [IDXW*NREQ-1:0] idx,  idx2;
    logic [NREQ-1:0]      gnt,  gnt2;
    logic                 ack,  ack2;
    logic                 err,  err2;
    logic                 busy, busy2;
    logic [WIDTH-1:0]     q;
    logic [W2-1:0]        q2;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .idx(idx),
        .gnt(gnt), .ack(ack), .err(err), .busy(busy), .q(q)
    );

    jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(W2)) dut_w6 (
        .clk(clk), .rst(rst), .req(req2), .cmd(cmd2), .idx(idx2),
        .gnt(gnt2), .ack(ack2), .err(err2), .busy(busy2), .q(q2)
    );

    // Transaction model of the main instance: a command occupies three cycles.
    logic [WIDTH-1:0] m_q;
    logic [1:0]       m_jk;
    logic             m_err;
    int               m_ptr, m_slot, m_w, m_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q = '0; m_jk = 2'b00; m_err = 1'b0;
            m_ptr = 0; m_slot = 0; m_w = 0; m_idx = 0;
        end else if (m_slot == 0) begin
            for (int o = 0; o < int'(NREQ); o++) begin
                if (m_slot == 0 && req[(m_ptr + o) % NREQ]) begin
                    m_w    = (m_ptr + o) % NREQ;
                    m_jk   = cmd[2*m_w +: 2];
                    m_idx  = int'(idx[IDXW*m_w +: IDXW]);
                    m_slot = 1;
                end
            end
        end else if (m_slot == 1) begin
            m_err = (m_idx >= int'(WIDTH));
            if (!m_err) begin
                if (m_jk == 2'b01) m_q[m_idx] = 1'b0;
                else if (m_jk == 2'b10) m_q[m_idx] = 1'b1;
                else if (m_jk == 2'b11) m_q[m_idx] = ~m_q[m_idx];
            end
            m_ptr  = (m_w + 1) % NREQ;
            m_slot = 2;
        end else begin
            m_err  = 1'b0;
            m_slot = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle_check();
        logic [NREQ-1:0] e_gnt;
        if (rst === 1'b0) begin
            e_gnt = '0;
            if (m_slot != 0) e_gnt[m_w] = 1'b1;
            n_vec++;
            if (gnt !== e_gnt || ack !== (m_slot == 2) || err !== m_err ||
                busy !== (m_slot != 0) || q !== m_q) begin
                n_fail++;
                $display("FAIL cycle t=%0t gnt %b/%b ack %b/%b err %b/%b busy %b/%b q %h/%h",
                         $time, gnt, e_gnt, ack, (m_slot == 2), err, m_err,
                         busy, (m_slot != 0), q, m_q);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_check();
    endtask

    task automatic wait_ack(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            tick();
            if (ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL ack_timeout: no ack within %0d cycles", bound);
        end
    endtask

    task automatic wait_ack2(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (ack2 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL ack2_timeout: no ack within %0d cycles", bound);
        end
    endtask

    task automatic issue(input int r, input logic [1:0] jk, input int ix);
        bit ok;
        req[r]             = 1'b1;
        cmd[2*r +: 2]      = jk;
        idx[IDXW*r +: IDXW] = IDXW'(ix);
        wait_ack(20, ok);
        req[r] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < int'(NREQ); i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        bit ok;
        int grants[$];
        int ack_cyc[$];
        int ptrs[$];
        logic [NREQ-1:0] prev_gnt;
        int cyc;

        rst = 1'b1; req = '0; cmd = '0; idx = '0;
        req2 = '0; cmd2 = '0; idx2 = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_ack", 32'(ack), 32'h0);

        // Single set on bit 3 by requester 0.
        req = 4'b0001; cmd[1:0] = 2'b10; idx[2:0] = 3'd3;
        tick();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        tick();
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_q", 32'(q), 32'h08);
        req = '0;
        tick();
        chk("single_done_gnt", 32'(gnt), 32'h0);

        // Two toggles of bit 7 from a cleared bank.
        do_reset();
        issue(2, 2'b11, 7);
        chk("toggle1_q", 32'(q), 32'h80);
        issue(2, 2'b11, 7);
        chk("toggle2_q", 32'(q), 32'h00);

        // Build A5, then reset asynchronously while a command is mid-APPLY.
        issue(0, 2'b10, 0);
        issue(0, 2'b10, 2);
        issue(0, 2'b10, 5);
        issue(0, 2'b10, 7);
        chk("build_a5", 32'(q), 32'hA5);
        req[1] = 1'b1; cmd[3:2] = 2'b11; idx[5:3] = 3'd1;
        tick(); tick();
        chk("apply_gnt", 32'(gnt), 32'h2);
        chk("apply_noack", 32'(ack), 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("async_q", 32'(q), 32'h0);
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_ack", 32'(ack), 32'h0);
        req = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_busy", 32'(busy), 32'h0);
        chk("post_reset_q", 32'(q), 32'h0);

        // Full contention: everyone toggles its own bit.
        cmd = 8'hFF;
        idx = {3'd3, 3'd2, 3'd1, 3'd0};
        req = 4'b1111;
        prev_gnt = '0;
        cyc = 0;
        while (ack_cyc.size() < 5 && cyc < 40) begin
            tick();
            cyc++;
            if (gnt != 0 && prev_gnt == 0) begin
                chk("contend_onehot", 32'($onehot(gnt)), 32'h1);
                grants.push_back(oh2i(gnt));
            end
            if (ack === 1'b1) ack_cyc.push_back(cyc);
            prev_gnt = gnt;
        end
        req = '0;
        chk("contend_acks", 32'(ack_cyc.size()), 32'd5);
        if (grants.size() == 5) begin
            chk("contend_g0", 32'(grants[0]), 32'd0);
            chk("contend_g1", 32'(grants[1]), 32'd1);
            chk("contend_g2", 32'(grants[2]), 32'd2);
            chk("contend_g3", 32'(grants[3]), 32'd3);
            chk("contend_g4", 32'(grants[4]), 32'd0);
        end else begin
            chk("contend_grants", 32'(grants.size()), 32'd5);
        end
        for (int i = 1; i < ack_cyc.size(); i++)
            chk("contend_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        chk("contend_q", 32'(q), 32'h0E);
        tick();

        // Rotation with requesters 1 and 3 from ptr=0.
        do_reset();
        cmd = '0;
        idx = '0;
        grants.delete();
        req = 4'b1010;
        cyc = 0;
        while (grants.size() < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (ack === 1'b1) begin
                grants.push_back(oh2i(gnt));
                ptrs.push_back(m_ptr);
            end
        end
        req = '0;
        if (grants.size() == 4) begin
            chk("rot_g0", 32'(grants[0]), 32'd1);
            chk("rot_g1", 32'(grants[1]), 32'd3);
            chk("rot_g2", 32'(grants[2]), 32'd1);
            chk("rot_g3", 32'(grants[3]), 32'd3);
            chk("rot_ptr0", 32'(ptrs[0]), 32'd2);
            chk("rot_ptr1", 32'(ptrs[1]), 32'd0);
            chk("rot_ptr2", 32'(ptrs[2]), 32'd2);
            chk("rot_ptr3", 32'(ptrs[3]), 32'd0);
        end else begin
            chk("rot_acks", 32'(grants.size()), 32'd4);
        end
        tick(); tick();

        // Out-of-range index on the six-bit instance.
        req2 = 4'b0001; cmd2[1:0] = 2'b10; idx2[2:0] = 3'd5;
        wait_ack2(20, ok);
        req2 = '0;
        chk("w6_set_err", 32'(err2), 32'h0);
        chk("w6_set_q", 32'(q2), 32'h20);
        @(negedge clk);
        req2 = 4'b0001; idx2[2:0] = 3'd7;
        wait_ack2(20, ok);
        req2 = '0;
        chk("w6_range_ack", 32'(ack2), 32'h1);
        chk("w6_range_err", 32'(err2), 32'h1);
        chk("w6_range_q", 32'(q2), 32'h20);
        @(negedge clk);
        chk("w6_err_clear", 32'(err2), 32'h0);
        chk("w6_idle_busy", 32'(busy2), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
